// File: rtl/switch_pkg.sv
// Shared types and constants for the flooding switch core: frame beat layout,
// the forwarding FSM states and the beat used to terminate aborted frames.
package switch_pkg;
    localparam int FRAME_BEAT_WIDTH = 9;
    localparam int LAST_BIT         = 8;
    localparam logic [FRAME_BEAT_WIDTH-1:0] ABORT_BEAT = 9'h100;

    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        DROP,
        ABORT
    } switch_state_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin search: first requester after last_grant, wrapping.
// The parent owns and registers last_grant.
module round_robin_arbiter #(
    parameter int WIDTH       = 4,
    parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]       request,
    input  logic [INDEX_WIDTH-1:0] last_grant,
    output logic [INDEX_WIDTH-1:0] grant,
    output logic                   grant_valid
);
    // Bit i of rotated is the requester at position last_grant+1+i (mod WIDTH).
    logic [WIDTH-1:0] rotated;

    assign rotated = WIDTH'({request, request} >> (int'(last_grant) + 1));

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                grant       = INDEX_WIDTH'((int'(last_grant) + 1 + i) % WIDTH);
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_flood_arbiter.sv
// N-port frame flooder: round-robin ingress grant per frame, registered egress with
// backpressure, starvation timeout and drop of undeliverable frames.
// Optional per-port frame counters are enabled with SWITCH_FRAME_COUNTERS_EN.
module switch_flood_arbiter
    import switch_pkg::*;
#(
    parameter int NUMBER_OF_PORTS  = 4,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int PORT_INDEX_WIDTH = $clog2(NUMBER_OF_PORTS)
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_PORTS-1:0][FRAME_BEAT_WIDTH-1:0] ingress_data,
    input  logic [NUMBER_OF_PORTS-1:0]                       ingress_data_valid,
    output logic [NUMBER_OF_PORTS-1:0]                       ingress_data_ready,
    output logic [NUMBER_OF_PORTS-1:0][FRAME_BEAT_WIDTH-1:0] egress_data,
    output logic [NUMBER_OF_PORTS-1:0]                       egress_data_valid,
    input  logic [NUMBER_OF_PORTS-1:0]                       egress_data_ready,
    input  logic [NUMBER_OF_PORTS-1:0]                       port_enable,
    output logic [PORT_INDEX_WIDTH-1:0]                      active_port,
    output logic                                             busy,
    output logic                                             frame_aborted
`ifdef SWITCH_FRAME_COUNTERS_EN
    ,
    output logic [NUMBER_OF_PORTS-1:0][15:0]                 forwarded_frame_count,
    output logic [NUMBER_OF_PORTS-1:0][15:0]                 dropped_frame_count
`endif
);
    localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES);

    switch_state_t                state_reg, state_next;
    logic [PORT_INDEX_WIDTH-1:0]  grant_reg, grant_next;
    logic [PORT_INDEX_WIDTH-1:0]  last_grant_reg, last_grant_next;
    logic [NUMBER_OF_PORTS-1:0]   dest_mask_reg, dest_mask_next;
    logic [TIMEOUT_WIDTH-1:0]     timeout_reg, timeout_next;
    logic                         aborted_reg, aborted_next;
    logic [PORT_INDEX_WIDTH-1:0]  active_port_reg;

    logic [PORT_INDEX_WIDTH-1:0]  arb_grant;
    logic                         arb_valid;
    logic [NUMBER_OF_PORTS-1:0]   slot_free;
    logic                         dest_free;
    logic [NUMBER_OF_PORTS-1:0]   load_mask;
    logic [FRAME_BEAT_WIDTH-1:0]  load_beat;

    round_robin_arbiter #(
        .WIDTH       (NUMBER_OF_PORTS),
        .INDEX_WIDTH (PORT_INDEX_WIDTH)
    ) u_arbiter (
        .request     (ingress_data_valid & port_enable),
        .last_grant  (last_grant_reg),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign slot_free = ~egress_data_valid | egress_data_ready;
    assign dest_free = &(slot_free | ~dest_mask_reg);

    always_comb begin
        state_next         = state_reg;
        grant_next         = grant_reg;
        last_grant_next    = last_grant_reg;
        dest_mask_next     = dest_mask_reg;
        timeout_next       = timeout_reg;
        aborted_next       = 1'b0;
        ingress_data_ready = '0;
        load_mask          = '0;
        load_beat          = ingress_data[grant_reg];
        case (state_reg)
            IDLE: begin
                timeout_next = '0;
                if (arb_valid) begin
                    grant_next     = arb_grant;
                    dest_mask_next = port_enable & ~(NUMBER_OF_PORTS'(1) << arb_grant);
                    state_next     = (dest_mask_next != '0) ? FORWARD : DROP;
                end
            end
            FORWARD: begin
                ingress_data_ready[grant_reg] = dest_free;
                if (ingress_data_valid[grant_reg] && dest_free) begin
                    load_mask    = dest_mask_reg;
                    timeout_next = '0;
                    if (ingress_data[grant_reg][LAST_BIT]) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end
                end else if (dest_free) begin
                    // Only starvation with room downstream counts toward the timeout.
                    if (timeout_reg == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        aborted_next = 1'b1;
                        timeout_next = '0;
                        state_next   = ABORT;
                    end else begin
                        timeout_next = timeout_reg + TIMEOUT_WIDTH'(1);
                    end
                end
            end
            DROP: begin
                ingress_data_ready[grant_reg] = 1'b1;
                if (ingress_data_valid[grant_reg] && ingress_data[grant_reg][LAST_BIT]) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            ABORT: begin
                // The ingress frame is never finished here; its tail is swallowed in DROP.
                if (dest_free) begin
                    load_mask  = dest_mask_reg;
                    load_beat  = ABORT_BEAT;
                    state_next = DROP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            last_grant_reg  <= PORT_INDEX_WIDTH'(NUMBER_OF_PORTS - 1);
            dest_mask_reg   <= '0;
            timeout_reg     <= '0;
            aborted_reg     <= 1'b0;
            active_port_reg <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            dest_mask_reg   <= dest_mask_next;
            timeout_reg     <= timeout_next;
            aborted_reg     <= aborted_next;
            active_port_reg <= (state_next == IDLE) ? last_grant_next : grant_next;
        end
    end

    for (genvar gi = 0; gi < NUMBER_OF_PORTS; gi++) begin : g_egress
        logic [FRAME_BEAT_WIDTH-1:0] data_reg;
        logic                        valid_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (load_mask[gi]) begin
                data_reg  <= load_beat;
                valid_reg <= 1'b1;
            end else if (egress_data_ready[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign egress_data[gi]       = data_reg;
        assign egress_data_valid[gi] = valid_reg;
    end

`ifdef SWITCH_FRAME_COUNTERS_EN
    logic forward_done;
    logic drop_event;

    assign forward_done = (state_reg == FORWARD) && (state_next == IDLE);
    assign drop_event   = ((state_reg == IDLE) && (state_next == DROP)) || aborted_next;

    for (genvar gi = 0; gi < NUMBER_OF_PORTS; gi++) begin : g_counters
        logic [15:0] forwarded_reg;
        logic [15:0] dropped_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                forwarded_reg <= '0;
                dropped_reg   <= '0;
            end else begin
                if (forward_done && grant_reg == PORT_INDEX_WIDTH'(gi) && forwarded_reg != 16'hFFFF)
                    forwarded_reg <= forwarded_reg + 16'd1;
                if (drop_event && grant_next == PORT_INDEX_WIDTH'(gi) && dropped_reg != 16'hFFFF)
                    dropped_reg <= dropped_reg + 16'd1;
            end
        end

        assign forwarded_frame_count[gi] = forwarded_reg;
        assign dropped_frame_count[gi]   = dropped_reg;
    end
`endif

    assign busy          = (state_reg != IDLE);
    assign frame_aborted = aborted_reg;
    assign active_port   = active_port_reg;
endmodule
